// File: rtl/lbc_pkg.sv
// ---------------------------------------------------------------------------
// lbc_pkg -- definitions shared by the log-to-binary conversion scheduler.
//   EXP_W / FRAC_W : field widths of a log-sum operand
//   EXP_BIAS       : exponent at which the mantissa is passed through unshifted
//   sumlog_t       : log-sum operand {exponent, fraction}
// ---------------------------------------------------------------------------
package lbc_pkg;

    localparam int EXP_W    = 5;
    localparam int FRAC_W   = 15;
    localparam int EXP_BIAS = 15;

    typedef struct packed {
        logic [EXP_W-1:0]  exponent;
        logic [FRAC_W-1:0] fraction;
    } sumlog_t;

endpackage

// File: rtl/lbc_core.sv
// ---------------------------------------------------------------------------
// lbc_core -- purely combinational log-to-binary conversion.
//   sumlog : operand {exponent e, fraction f}
//   result : e == 0  -> 1
//            else m = {1, f}; e < 15 -> m >> (15-e); e == 15 -> m;
//                             e > 15 -> m << (e-15)
// With RES_W = 32 the largest case (e = 31) fills exactly bits [31:16].
// ---------------------------------------------------------------------------
module lbc_core
    import lbc_pkg::*;
#(
    parameter int RES_W = 32
) (
    input  sumlog_t          sumlog,
    output logic [RES_W-1:0] result
);

    logic [RES_W-1:0] m;
    int               e;

    // NOTE: every variable in an always_comb gets a value on every path
    // (defaults first) so no latch is inferred.
    always_comb begin
        e = int'(sumlog.exponent);
        m = RES_W'({1'b1, sumlog.fraction});
        if (e == 0) begin
            result = RES_W'(1);
        end else if (e <= EXP_BIAS) begin
            result = m >> (EXP_BIAS - e);
        end else begin
            result = m << (e - EXP_BIAS);
        end
    end

endmodule

// File: rtl/lbc_sched.sv
// ---------------------------------------------------------------------------
// lbc_sched -- round-robin scheduler sharing one lbc_core between NREQ
// requesters, with a two-stage valid/ready pipeline.
//   clk, rst            : clock, synchronous active-high reset
//   req_valid/req_ready : per-requester handshake (req_ready one-hot or zero)
//   req_sumlog          : packed operands, requester i at [i*SUM_W +: SUM_W]
//   out_valid/out_ready : result handshake
//   out_result, out_id  : converted value and owning requester
//   conv_count          : saturating output-transfer counter, present only
//                         when LBC_SCHED_PERF_EN is defined
// ---------------------------------------------------------------------------
module lbc_sched
    import lbc_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int SUM_W = 20,
    parameter int RES_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*SUM_W-1:0]    req_sumlog,
    output logic [NREQ-1:0]          req_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [RES_W-1:0]         out_result,
    output logic [$clog2(NREQ)-1:0]  out_id
`ifdef LBC_SCHED_PERF_EN
    ,
    output logic [15:0]              conv_count
`endif
);

    localparam int ID_W = $clog2(NREQ);

    logic [ID_W-1:0]  last_grant;
    logic [ID_W-1:0]  grant_idx;
    logic             grant_found;
    int               idx;

    logic             s1_valid;
    sumlog_t          s1_sumlog;
    logic [ID_W-1:0]  s1_id;
    logic             s2_valid;
    logic [RES_W-1:0] s2_result;
    logic [ID_W-1:0]  s2_id;

    logic             s2_load;
    logic             s1_load;
    logic             req_fire;
    sumlog_t          req_op;
    logic [RES_W-1:0] conv_result;

    // Round-robin search starting one past the last grant, wrapping.
    // NOTE: blocking '=' inside always_comb, non-blocking '<=' in always_ff.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(last_grant) + k) % NREQ;
            if (!grant_found && req_valid[idx]) begin
                grant_found = 1'b1;
                grant_idx   = idx[ID_W-1:0];
            end
        end
    end

    // Stage 2 loads when empty or draining; stage 1 loads when empty or
    // advancing, so drain, advance and accept can all happen in one cycle.
    assign s2_load  = !s2_valid || out_ready;
    assign s1_load  = !s1_valid || s2_load;
    assign req_fire = grant_found && s1_load && !rst;

    always_comb begin
        req_ready = '0;
        if (req_fire) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    assign req_op = sumlog_t'(req_sumlog[grant_idx*SUM_W +: SUM_W]);

    lbc_core #(.RES_W(RES_W)) u_core (
        .sumlog (s1_sumlog),
        .result (conv_result)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s2_valid   <= 1'b0;
            s2_result  <= '0;
            s2_id      <= '0;
            last_grant <= ID_W'(NREQ - 1);
        end else begin
            if (s2_load) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_result <= conv_result;
                    s2_id     <= s1_id;
                end
            end
            if (s1_load) begin
                s1_valid <= req_fire;
                if (req_fire) begin
                    last_grant <= grant_idx;
                end
            end
        end
    end

    // NOTE: stage-1 payload has no reset; it is only ever consumed while
    // s1_valid is set, so resetting it would add logic without effect.
    always_ff @(posedge clk) begin
        if (req_fire) begin
            s1_sumlog <= req_op;
            s1_id     <= grant_idx;
        end
    end

    assign out_valid  = s2_valid;
    assign out_result = s2_result;
    assign out_id     = s2_id;

`ifdef LBC_SCHED_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            conv_count <= '0;
        end else if (out_valid && out_ready && conv_count != 16'hFFFF) begin
            conv_count <= conv_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_lbc_sched.sv
// ---------------------------------------------------------------------------
// tb_lbc_sched -- directed self-checking bench for lbc_sched (defaults).
// Inputs change on the falling edge; outputs are sampled 2 time units later.
// Accepted requests are pushed into a scoreboard with an independently
// computed expected result and popped when the matching output transfers.
// ---------------------------------------------------------------------------
module tb_lbc_sched;

    localparam int NREQ  = 4;
    localparam int SUM_W = 20;
    localparam int RES_W = 32;

    typedef struct {
        logic [1:0]  id;
        logic [31:0] res;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*SUM_W-1:0] req_sumlog;
    logic [NREQ-1:0]       req_ready;
    logic                  out_valid;
    logic                  out_ready;
    logic [RES_W-1:0]      out_result;
    logic [1:0]            out_id;
`ifdef LBC_SCHED_PERF_EN
    logic [15:0]           conv_count;
`endif

    exp_t        sb[$];
    logic [31:0] got[$];
    int          grants[$];
    int          checks = 0;
    int          errors = 0;
    int          acc_count = 0;
    int          out_seen = 0;
    logic [1:0]  lg_model = 2'd3;
    logic [3:0]  last_acc = '0;
    logic        oneshot = 1'b1;

    lbc_sched #(.NREQ(NREQ), .SUM_W(SUM_W), .RES_W(RES_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_sumlog (req_sumlog),
        .req_ready  (req_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_id     (out_id)
`ifdef LBC_SCHED_PERF_EN
        ,
        .conv_count (conv_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference conversion written as one wide shift: (m << e) >> 15.
    function automatic logic [31:0] conv_model(input logic [19:0] s);
        logic [63:0] m;
        m = {48'd0, 1'b1, s[14:0]};
        if (s[19:15] == 5'd0) return 32'd1;
        return 32'((m << s[19:15]) >> 15);
    endfunction

    function automatic int rr_pick(input logic [3:0] v, input logic [1:0] lg);
        int j;
        for (int k = 1; k <= NREQ; k++) begin
            j = (int'(lg) + k) % NREQ;
            if (v[j]) return j;
        end
        return -1;
    endfunction

    task automatic set_op(input int i, input logic [4:0] e, input logic [14:0] f);
        req_sumlog[i*SUM_W +: SUM_W] = {e, f};
    endtask

    task automatic sample();
        logic [3:0] acc;
        exp_t       e;
        acc = '0;
        #2;
        check("ready_onehot0", 64'($onehot0(req_ready)), 64'd1);
        if (rst) begin
            check("ready_in_reset", 64'(req_ready), 64'd0);
        end else begin
            if (out_valid && out_ready) begin
                out_seen++;
                got.push_back(out_result);
                check("sb_has_entry", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("out_id", 64'(out_id), 64'(e.id));
                    check("out_result", 64'(out_result), 64'(e.res));
                end
            end
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    check("rr_grant", 64'(i), 64'(rr_pick(req_valid, lg_model)));
                    lg_model = 2'(i);
                    sb.push_back('{2'(i), conv_model(req_sumlog[i*SUM_W +: SUM_W])});
                    grants.push_back(i);
                    acc[i] = 1'b1;
                    acc_count++;
                end
            end
        end
        last_acc = acc;
    endtask

    task automatic step();
        sample();
        @(posedge clk);
        @(negedge clk);
        if (oneshot) req_valid = req_valid & ~last_acc;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        lg_model = 2'd3;
        sb.delete();
    endtask

    task automatic drain(input string tag);
        for (int c = 0; c < 20 && sb.size() != 0; c++) step();
        check(tag, 64'(sb.size()), 64'd0);
    endtask

    initial begin
        logic [31:0] snap_res;
        logic [1:0]  snap_id;
        int          acc0;

        rst        = 1'b1;
        req_valid  = '0;
        req_sumlog = '0;
        out_ready  = 1'b1;
        @(negedge clk);
        step();
        // Second reset cycle: requests present but nothing may be granted.
        req_valid = 4'hF;
        #2;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_result", 64'(out_result), 64'd0);
        check("rst_out_id", 64'(out_id), 64'd0);
        #0;
        step();
        rst = 1'b0;
        req_valid = '0;
        lg_model = 2'd3;

        // Single request, latency 2.
        set_op(0, 5'd15, 15'h0000);
        req_valid = 4'b0001;
        #1;
        check("single_ready", 64'(req_ready), 64'b0001);
        step();
        check("lat_n1_valid", 64'(out_valid), 64'd0);
        step();
        check("lat_n2_valid", 64'(out_valid), 64'd1);
        check("single_result", 64'(out_result), 64'h0000_8000);
        check("single_id", 64'(out_id), 64'd0);
        drain("single_drain");

        // Shift boundaries, back to back on requester 0.
        got.delete();
        set_op(0, 5'd0,  15'h1234); req_valid = 4'b0001; step();
        set_op(0, 5'd1,  15'h0000); req_valid = 4'b0001; step();
        set_op(0, 5'd16, 15'h0000); req_valid = 4'b0001; step();
        set_op(0, 5'd31, 15'h7FFF); req_valid = 4'b0001; step();
        drain("shift_drain");
        check("shift_count", 64'(got.size()), 64'd4);
        if (got.size() == 4) begin
            check("shift_e0",  64'(got[0]), 64'h0000_0001);
            check("shift_e1",  64'(got[1]), 64'h0000_0002);
            check("shift_e16", 64'(got[2]), 64'h0001_0000);
            check("shift_e31", 64'(got[3]), 64'hFFFF_0000);
        end

        // Fairness: all four valid continuously after reset.
        do_reset();
        set_op(0, 5'd20, 15'h0001);
        set_op(1, 5'd3,  15'h4000);
        set_op(2, 5'd15, 15'h7FFF);
        set_op(3, 5'd25, 15'h2AAA);
        grants.delete();
        oneshot   = 1'b0;
        req_valid = 4'hF;
        for (int c = 0; c < 8; c++) step();
        check("fair_count", 64'(grants.size()), 64'd8);
        for (int c = 0; c < 8 && c < grants.size(); c++)
            check("fair_order", 64'(grants[c]), 64'(c % 4));
        oneshot   = 1'b1;
        req_valid = '0;
        drain("fair_drain");

        // Backpressure: 3 pending, out_ready low 5 cycles.
        got.delete();
        out_seen  = 0;
        acc0      = acc_count;
        out_ready = 1'b0;
        req_valid = 4'b0111;
        snap_res  = '0;
        snap_id   = '0;
        for (int c = 0; c < 5; c++) begin
            if (c == 2) begin
                check("bp_valid", 64'(out_valid), 64'd1);
                snap_res = out_result;
                snap_id  = out_id;
            end
            if (c > 2) begin
                check("bp_result_stable", 64'(out_result), 64'(snap_res));
                check("bp_id_stable", 64'(out_id), 64'(snap_id));
            end
            step();
        end
        check("bp_accepted", 64'(acc_count - acc0), 64'd2);
        out_ready = 1'b1;
        for (int c = 0; c < 20 && req_valid != '0; c++) step();
        check("bp_all_accepted", 64'(req_valid), 64'd0);
        drain("bp_drain");
        check("bp_outputs", 64'(out_seen), 64'd3);

        // Reset while both stages are full.
        out_ready = 1'b0;
        set_op(3, 5'd10, 15'h1111);
        req_valid = 4'b1010;
        step();
        step();
        check("mid_full", 64'(out_valid), 64'd1);
        req_valid = '0;
        do_reset();
        #1;
        check("mid_after_rst_valid", 64'(out_valid), 64'd0);
        out_ready = 1'b1;
        out_seen  = 0;
        req_valid = 4'b1111;
        #1;
        check("mid_first_grant", 64'(req_ready), 64'b0001);
        step();
        req_valid = '0;
        for (int c = 0; c < 6; c++) step();
        check("mid_no_stale", 64'(out_seen), 64'd1);
        check("mid_sb_empty", 64'(sb.size()), 64'd0);

`ifdef LBC_SCHED_PERF_EN
        do_reset();
        check("perf_rst_zero", 64'(conv_count), 64'd0);
        out_seen  = 0;
        oneshot   = 1'b0;
        req_valid = 4'hF;
        for (int c = 0; c < 100; c++) step();
        check("perf_mid", 64'(conv_count), 64'(out_seen));
        for (int c = 0; c < 70000; c++) step();
        check("perf_sat", 64'(conv_count), 64'hFFFF);
        oneshot   = 1'b1;
        req_valid = '0;
        drain("perf_drain");
        do_reset();
        check("perf_cleared", 64'(conv_count), 64'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lbc_sched.md
LBC_SCHED -- requirements
Module: lbc_sched

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing one log-to-binary conversion unit (2..8).
REQ-002 Parameter SUM_W, default 20, log-sum width: 5-bit exponent [19:15] plus 15-bit fraction [14:0].
REQ-003 Parameter RES_W, default 32, binary result width.
REQ-004 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-005 Port rst, input, 1: reset, synchronous, active-high.
REQ-006 Port req_valid, input, NREQ: per-requester request valid.
REQ-007 Port req_sumlog, input, NREQ*SUM_W: packed log-sum operands; requester i uses bits [i*SUM_W +: SUM_W].
REQ-008 Port req_ready, output, NREQ: per-requester accept, one-hot or zero.
REQ-009 Port out_valid, output, 1: result valid.
REQ-010 Port out_ready, input, 1: downstream accept.
REQ-011 Port out_result, output, RES_W: converted binary value.
REQ-012 Port out_id, output, $clog2(NREQ): index of the requester that owns out_result.

Function
REQ-013 Transfer rules: a request transfers when req_valid[i] and req_ready[i] are both high; an output transfers when out_valid and out_ready are both high.
REQ-014 Arbitration: round-robin. Search starts at last_grant+1 and wraps modulo NREQ. The first requester with valid high is the grant candidate.
REQ-015 req_ready[i] is high only for the grant candidate, and only while stage 1 can load.
- Stage 1 can load when it is empty, or when its content advances in the same cycle.
REQ-016 last_grant updates only on a request transfer. Requesters that are valid but not granted hold; dropping valid without a transfer is permitted.
REQ-017 Pipeline: two register stages.
- Stage 1 captures {sumlog, id} on a request transfer.
- Stage 2 captures the converted result and id from stage 1.
REQ-018 Latency: a transfer in cycle N gives out_valid in cycle N+2 when out_ready is high throughout. Throughput is one result per cycle.
REQ-019 Backpressure: while out_valid=1 and out_ready=0, the following hold stable: out_result, out_id and the stage-1 content. Stage 1 accepts a new request only if it is empty.
REQ-020 Conversion of exponent e and fraction f:
- e=0 gives result = 1.
- Otherwise m = {1'b1, f}, zero-extended to RES_W.
- 1<=e<=14 gives m >> (15-e); e=15 gives m; 16<=e<=31 gives m << (e-15).
- Width rule: no bits are lost above bit 31 at e=31.
REQ-021 Simultaneous events: stage-2 drain, stage-1 advance and a new request transfer in the same cycle all complete, with no bubble.
REQ-022 Results leave in acceptance order. The block never reorders, duplicates or drops an accepted request.

Reset
REQ-023 With rst high at a clock edge, both stages become empty and last_grant is set to NREQ-1, so requester 0 has first priority.
- Outputs after reset: out_valid=0, out_result=0, out_id=0, req_ready=0 during the reset cycle.
REQ-024 Reset asserted mid-operation discards in-flight operations. out_valid is low in the cycle after the reset edge, and no stale result is later presented.

Configuration
REQ-025 Macro LBC_SCHED_PERF_EN defined: extra output port conv_count, 16 bits.
- Counts output transfers.
- Saturates at 16'hFFFF.
- Cleared by rst.
REQ-026 LBC_SCHED_PERF_EN undefined: the conv_count port and its counter are absent, and all other behaviour is identical.

Structure
REQ-027 The shared package lbc_pkg holds:
- constants EXP_W=5, FRAC_W=15, EXP_BIAS=15;
- typedef sumlog_t (struct of exponent and fraction).
REQ-028 Conversion is one purely combinational sub-module, lbc_core (sumlog_t in, RES_W out), instantiated once between stage 1 and stage 2. The arbiter and pipeline control stay in lbc_sched.

Verification
REQ-029 Single request: req 0, sumlog {15, 15'h0000}, out_ready=1 -> out_valid two cycles later, out_result=32'h0000_8000, out_id=0.
REQ-030 Shift boundaries, in turn:
- {0, 15'h1234} -> 32'h0000_0001
- {1, 0} -> 32'h0000_0002
- {16, 0} -> 32'h0001_0000
- {31, 15'h7FFF} -> 32'hFFFF_0000
REQ-031 Fairness: all 4 requesters valid continuously after reset, out_ready=1 -> grant order 0,1,2,3,0,... with one accept per cycle.
REQ-032 Backpressure: out_ready low for 5 cycles with 3 requests pending -> out_result and out_id stable, at most 2 requests accepted; on release the results drain in acceptance order with no loss.
REQ-033 Reset mid-flight: rst high one cycle while both stages are full -> out_valid=0 the next cycle; the first request after reset is served from requester 0.
REQ-034 With LBC_SCHED_PERF_EN: 70000 output transfers -> conv_count=16'hFFFF; rst -> 0.
